// File: rtl/mem_access_unit_if.sv
// Single-beat data-memory bus between the MEM-stage access unit (master)
// and the data memory (slave).
interface mem_access_unit_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic [7:0]  dmem_wstrb;
  logic        dmem_ack;
  logic [63:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: checks alignment, drives a request/ack bus with
// a bounded wait, and formats load data for the MEM/WB register.
module mem_access_unit #(
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [63:0]       addr,
  input  logic [63:0]       wdata,
  mem_access_unit_if.master bus,
  output logic [63:0]       data,
  output logic              stall,
  output logic              misaligned,
  output logic              bus_err
);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             req_r;
  logic             we_r;
  logic [63:0]      addr_r;
  logic [63:0]      wdata_r;
  logic [7:0]       wstrb_r;
  logic [2:0]       funct3_r;
  logic [2:0]       off_r;
  logic             is_load_r;
  logic [63:0]      data_r;
  logic             misaligned_r;
  logic             bus_err_r;
  logic             stall_s;
  logic             access_s;
  logic             store_s;
  logic             misal_s;

  // funct3[1:0] encodes the access size for every code, 111 included.
  function automatic logic is_misaligned_f(input logic [2:0] f3, input logic [2:0] o);
    case (f3[1:0])
      2'b00:   is_misaligned_f = 1'b0;
      2'b01:   is_misaligned_f = o[0];
      2'b10:   is_misaligned_f = |o[1:0];
      2'b11:   is_misaligned_f = |o;
      default: is_misaligned_f = 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] strobe_f(input logic [2:0] f3, input logic [2:0] o);
    case (f3[1:0])
      2'b00:   strobe_f = 8'h01 << o;
      2'b01:   strobe_f = 8'h03 << o;
      2'b10:   strobe_f = 8'h0F << o;
      2'b11:   strobe_f = 8'hFF;
      default: strobe_f = 8'h00;
    endcase
  endfunction

  function automatic logic [63:0] replicate_f(input logic [2:0] f3, input logic [63:0] wd);
    case (f3[1:0])
      2'b00:   replicate_f = {8{wd[7:0]}};
      2'b01:   replicate_f = {4{wd[15:0]}};
      2'b10:   replicate_f = {2{wd[31:0]}};
      2'b11:   replicate_f = wd;
      default: replicate_f = 64'd0;
    endcase
  endfunction

  function automatic logic [63:0] load_fmt_f(input logic [2:0] f3, input logic [2:0] o,
                                             input logic [63:0] rd);
    logic [31:0] lo;
    lo = 32'(rd >> {o, 3'b000});
    case (f3)
      3'b000:  load_fmt_f = {{56{lo[7]}}, lo[7:0]};
      3'b001:  load_fmt_f = {{48{lo[15]}}, lo[15:0]};
      3'b010:  load_fmt_f = {{32{lo[31]}}, lo[31:0]};
      3'b100:  load_fmt_f = {56'd0, lo[7:0]};
      3'b101:  load_fmt_f = {48'd0, lo[15:0]};
      3'b110:  load_fmt_f = {32'd0, lo[31:0]};
      default: load_fmt_f = rd;
    endcase
  endfunction

  // A simultaneous read and write is performed as a load only.
  assign access_s = mem_read | mem_write;
  assign store_s  = mem_write & ~mem_read;
  assign misal_s  = is_misaligned_f(funct3, addr[2:0]);

  // Stall decode: held through detect and wait cycles, released in DONE.
  always_comb begin
    stall_s = 1'b0;
    if (!reset) begin
      stall_s = 1'b0;
    end else begin
      case (state_r)
        IDLE:    stall_s = access_s;
        REQ:     stall_s = 1'b1;
        DONE:    stall_s = 1'b0;
        default: stall_s = 1'b0;
      endcase
    end
  end

  // Access sequencer with registered bus, result and fault outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      req_r        <= 1'b0;
      we_r         <= 1'b0;
      addr_r       <= 64'd0;
      wdata_r      <= 64'd0;
      wstrb_r      <= 8'h00;
      funct3_r     <= 3'b000;
      off_r        <= 3'b000;
      is_load_r    <= 1'b0;
      data_r       <= 64'd0;
      misaligned_r <= 1'b0;
      bus_err_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          misaligned_r <= 1'b0;
          bus_err_r    <= 1'b0;
          if (access_s && misal_s) begin
            misaligned_r <= 1'b1;
            data_r       <= 64'd0;
            state_r      <= DONE;
          end else if (access_s) begin
            req_r     <= 1'b1;
            we_r      <= store_s;
            addr_r    <= {addr[63:3], 3'b000};
            wdata_r   <= replicate_f(funct3, wdata);
            wstrb_r   <= store_s ? strobe_f(funct3, addr[2:0]) : 8'h00;
            funct3_r  <= funct3;
            off_r     <= addr[2:0];
            is_load_r <= mem_read;
            cnt_r     <= '0;
            state_r   <= REQ;
          end else begin
            state_r <= IDLE;
          end
        end
        REQ: begin
          if (bus.dmem_ack) begin
            req_r   <= 1'b0;
            we_r    <= 1'b0;
            state_r <= DONE;
            if (is_load_r) begin
              data_r <= load_fmt_f(funct3_r, off_r, bus.dmem_rdata);
            end else begin
              data_r <= data_r;
            end
          end else if (cnt_r == CNT_LAST) begin
            req_r     <= 1'b0;
            we_r      <= 1'b0;
            bus_err_r <= 1'b1;
            data_r    <= 64'd0;
            state_r   <= DONE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        DONE: begin
          misaligned_r <= 1'b0;
          bus_err_r    <= 1'b0;
          state_r      <= IDLE;
        end
        default: begin
          req_r   <= 1'b0;
          we_r    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.dmem_req   = req_r;
  assign bus.dmem_we    = we_r;
  assign bus.dmem_addr  = addr_r;
  assign bus.dmem_wdata = wdata_r;
  assign bus.dmem_wstrb = wstrb_r;
  assign data           = data_r;
  assign stall          = stall_s;
  assign misaligned     = misaligned_r;
  assign bus_err        = bus_err_r;
endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected load results/faults are queued
// when an access is driven and compared when the unit releases stall.
module tb_mem_access_unit;
  localparam int TO = 4;

  typedef struct {
    logic [63:0] data;
    logic        mis;
    logic        berr;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [63:0] data;
  logic        stall;
  logic        misaligned;
  logic        bus_err;

  mem_access_unit_if bus_if ();

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .bus        (bus_if.master),
    .data       (data),
    .stall      (stall),
    .misaligned (misaligned),
    .bus_err    (bus_err)
  );

  int          n_vectors;
  int          n_miscompares;
  exp_t        sb_q[$];
  logic [63:0] cur_data;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vectors++;
    if (obs !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int size_bytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic model_mis(input logic [2:0] f3, input logic [2:0] o);
    return (int'(o) % size_bytes(f3)) != 0;
  endfunction

  function automatic logic [7:0] model_strb(input logic [2:0] f3, input logic [2:0] o);
    logic [7:0] s;
    int n;
    n = size_bytes(f3);
    s = 8'h00;
    for (int i = 0; i < 8; i++) s[i] = (i >= int'(o)) && (i < int'(o) + n);
    return s;
  endfunction

  function automatic logic [63:0] model_wdata(input logic [2:0] f3, input logic [63:0] wd);
    logic [63:0] r;
    int n;
    n = size_bytes(f3);
    r = 64'd0;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [63:0] model_load(input logic [2:0] f3, input logic [2:0] o,
                                             input logic [63:0] rd);
    logic [63:0] v;
    int n;
    n = size_bytes(f3);
    v = 64'd0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = rd[8*(int'(o) + i) +: 8];
    if (!f3[2] && n < 8 && v[8*n-1]) begin
      for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
    end
    return v;
  endfunction

  // ack_at: REQ-cycle index in which ack is driven; negative or >= TO means never.
  task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] wd,
                        input logic [63:0] rdat, input int ack_at);
    exp_t e;
    logic mis;
    logic is_store;
    logic acked;
    int cyc;
    int exp_cyc;
    mis      = model_mis(f3, a[2:0]);
    is_store = wr & ~rd;
    acked    = (ack_at >= 0) && (ack_at < TO);
    exp_cyc  = mis ? 0 : (acked ? ack_at + 1 : TO);
    e.mis    = mis;
    e.berr   = !mis && !acked;
    if (mis || !acked) e.data = 64'd0;
    else if (rd) e.data = model_load(f3, a[2:0], rdat);
    else e.data = cur_data;
    cur_data = e.data;
    sb_q.push_back(e);

    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
    #1;
    check_eq("stall_detect", 64'(stall), 64'd1);
    @(posedge clk); #1;
    cyc = 0;
    while (stall === 1'b1 && cyc < TO + 2) begin
      check_eq("req_high", 64'(bus_if.dmem_req), 64'd1);
      check_eq("req_addr", bus_if.dmem_addr, {a[63:3], 3'b000});
      check_eq("req_we", 64'(bus_if.dmem_we), 64'(is_store));
      if (is_store) begin
        check_eq("req_wstrb", 64'(bus_if.dmem_wstrb), 64'(model_strb(f3, a[2:0])));
        check_eq("req_wdata", bus_if.dmem_wdata, model_wdata(f3, wd));
      end
      if (cyc == ack_at) begin
        bus_if.dmem_ack = 1'b1;
        bus_if.dmem_rdata = rdat;
      end
      @(posedge clk); #1;
      bus_if.dmem_ack = 1'b0;
      cyc++;
    end
    check_eq("req_cycles", 64'(cyc), 64'(exp_cyc));
    check_eq("done_req_low", 64'(bus_if.dmem_req), 64'd0);
    check_eq("done_we_low", 64'(bus_if.dmem_we), 64'd0);
    check_eq("sb_depth", 64'(sb_q.size()), 64'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq("done_data", data, e.data);
      check_eq("done_misaligned", 64'(misaligned), 64'(e.mis));
      check_eq("done_bus_err", 64'(bus_err), 64'(e.berr));
    end
    // Controls stay asserted through DONE: it must not launch another request.
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    #1;
    check_eq("after_req", 64'(bus_if.dmem_req), 64'd0);
    check_eq("after_stall", 64'(stall), 64'd0);
    check_eq("after_flags", {62'd0, misaligned, bus_err}, 64'd0);
    check_eq("after_data", data, cur_data);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_req"}, 64'(bus_if.dmem_req), 64'd0);
    check_eq({tag, "_we"}, 64'(bus_if.dmem_we), 64'd0);
    check_eq({tag, "_addr"}, bus_if.dmem_addr, 64'd0);
    check_eq({tag, "_wdata"}, bus_if.dmem_wdata, 64'd0);
    check_eq({tag, "_wstrb"}, 64'(bus_if.dmem_wstrb), 64'd0);
    check_eq({tag, "_data"}, data, 64'd0);
    check_eq({tag, "_flags"}, {62'd0, misaligned, bus_err}, 64'd0);
    check_eq({tag, "_stall"}, 64'(stall), 64'd0);
  endtask

  initial begin
    n_vectors = 0;
    n_miscompares = 0;
    cur_data = 64'd0;
    reset = 1'b0;
    mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b011;
    addr = 64'h100; wdata = 64'd0;
    bus_if.dmem_ack = 1'b0;
    bus_if.dmem_rdata = 64'd0;
    @(posedge clk); @(posedge clk); #1;
    check_all_zero("reset");
    mem_read = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;

    run_op(1'b1, 1'b0, 3'b000, 64'h1003, 64'd0, 64'h0000_0000_80FF_0000, 0);
    check_eq("lb_value", data, 64'hFFFF_FFFF_FFFF_FF80);
    run_op(1'b0, 1'b1, 3'b001, 64'h2006, 64'h1234, 64'd0, 2);
    check_eq("sh_keeps_data", data, 64'hFFFF_FFFF_FFFF_FF80);
    run_op(1'b1, 1'b0, 3'b010, 64'h1002, 64'd0, 64'd0, 0);
    run_op(1'b1, 1'b0, 3'b110, 64'h10, 64'd0, 64'hDEAD_BEEF_8000_0001, 0);
    check_eq("lwu_value", data, 64'h0000_0000_8000_0001);
    run_op(1'b1, 1'b0, 3'b011, 64'h3000, 64'd0, 64'h1111_2222_3333_4444, -1);
    run_op(1'b1, 1'b0, 3'b011, 64'h3008, 64'd0, 64'h1111_2222_3333_4444, TO - 1);
    run_op(1'b1, 1'b1, 3'b001, 64'h4002, 64'hAAAA, 64'h0000_0000_9876_0000, 1);
    run_op(1'b1, 1'b0, 3'b111, 64'h5000, 64'd0, 64'hCAFE_F00D_0123_4567, 0);
    run_op(1'b1, 1'b0, 3'b101, 64'h5005, 64'd0, 64'd0, 0);
    run_op(1'b0, 1'b1, 3'b000, 64'h6005, 64'h77, 64'd0, 0);
    run_op(1'b0, 1'b1, 3'b011, 64'h6008, 64'h0102_0304_0506_0708, 64'd0, -1);

    for (int k = 0; k < 24; k++) begin
      logic [1:0] kind;
      kind = 2'($urandom_range(0, 2));
      run_op(kind != 2'd1, kind != 2'd0, 3'($urandom_range(0, 7)),
             {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
             $urandom_range(0, TO + 1) - 1);
    end

    // Reset while waiting for ack, then a stray ack once idle.
    mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b011; addr = 64'h7000;
    @(posedge clk); #1;
    check_eq("rst_req_pending", 64'(bus_if.dmem_req), 64'd1);
    reset = 1'b0;
    #1;
    check_eq("rst_stall_low", 64'(stall), 64'd0);
    mem_read = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    cur_data = 64'd0;
    check_all_zero("rst_req");
    bus_if.dmem_ack = 1'b1;
    bus_if.dmem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk); #1;
    bus_if.dmem_ack = 1'b0;
    check_all_zero("late_ack");

    run_op(1'b1, 1'b0, 3'b000, 64'h8001, 64'd0, 64'h0000_0000_0000_7F00, 0);
    check_eq("post_reset_lb", data, 64'h0000_0000_0000_007F);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end
endmodule
